reg_readback_serializer: RTL and testbench
==========================================

Name: reg_readback_serializer

Overview:
- Reader side of the 16-bit DFF register: snapshots a register's parallel Q bus on request and streams it out one bit per accepted beat.
- Uses a valid/ready handshake.
- Feeds the debug/observation port of the multi-cycle 16-bit RISC computer, so any datapath register (PC, IR, A, B, ALUOut, MDR) can be read back without disturbing the datapath.

Parameters:
- WIDTH, 16, width of captured register and number of data beats (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a readback; sampled only in IDLE.
- q_in  input  WIDTH  parallel contents of the register being read.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- sdata  output  1  current serial bit.
- svalid  output  1  sdata is valid.
- sready  input  1  consumer accepts the beat when svalid&&sready at a rising edge.
- sfirst  output  1  high on the first beat of a frame.
- slast  output  1  high on the final beat of a frame.
- done  output  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: rst=1 at an edge forces IDLE.
  - Shadow register and beat counter are cleared.
  - busy, sdata, svalid, sfirst, slast and done are all 0 the next cycle.
  - Reset mid-frame aborts the frame; no done pulse is generated.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, svalid=0.
  - start=1 at edge N captures q_in into the shadow and clears the counter.
  - Next state is SHIFT; svalid=1 and busy=1 from cycle N+1.
  - Start-to-first-beat latency is 1 cycle.
- SHIFT:
  - svalid=1; sdata = shadow bit selected by counter and MSB_FIRST.
  - sfirst = (count==0); slast = (count==WIDTH-1).
  - Each edge with sready=1: count increments; the shadow shifts (MSB_FIRST=1: left; 0: right).
  - sready=0 stalls; sdata, sfirst and slast hold their values.
  - Accepted beat with slast=1 → DONE.
- DONE:
  - One cycle; done=1, svalid=0, busy=1.
  - Next state is IDLE unconditionally.
- start outside IDLE is ignored; it is not queued.
- q_in changes after capture do not affect the frame in progress.
- Back-to-back frames: start asserted on the DONE→IDLE cycle is accepted at that IDLE edge, so the minimum gap is 2 cycles with svalid=0.
- Counter width: clog2(WIDTH+1) bits; the counter never wraps within a frame.
- sdata is 0 whenever svalid=0.

Optional Feature:
- Macro: READBACK_PARITY_EN.
- Defined:
  - One extra beat follows the data beats, carrying even parity (XOR of all WIDTH captured bits).
  - slast moves to the parity beat, so the frame is WIDTH+1 beats.
  - done follows acceptance of the parity beat.
- Undefined:
  - No parity logic; the frame is exactly WIDTH beats.
  - slast is on beat WIDTH-1.

Test Plan:
1. q_in=16'hA5C3, start pulse, sready=1, MSB_FIRST=1 → sdata 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 consecutive cycles starting 1 cycle after start. sfirst on beat 0, slast on beat 15, done pulse on the next cycle, busy low after that.
2. Same frame with sready=0 during beats 3-5 → sdata=0 and sfirst=0 held for 3 stall cycles; full sequence still correct; done 3 cycles later than in scenario 1.
3. After capture of 16'h00FF, change q_in to 16'hFFFF and pulse start at beat 4 → output still 8 zeros then 8 ones; no second frame follows.
4. rst=1 at beat 7 → next cycle svalid=0, busy=0, no done. A new start with q_in=16'h8001 then sends 1, fourteen 0s, 1.
5. MSB_FIRST=0, q_in=16'h0003 → beats 0-1 carry 1, beats 2-15 carry 0.
6. READBACK_PARITY_EN defined, q_in=16'h0001 → 17 beats, beat 16 = 1 with slast=1. q_in=16'hA5C3 → parity beat = 0.

Source files
------------

// File: rtl/reg_readback_serializer_if.sv
// Serial readback stream bundle: one data bit per beat, valid/ready handshake.
// Framing flags mark the first and last beat of each register snapshot.
interface reg_readback_serializer_if;
  logic sdata;
  logic svalid;
  logic sready;
  logic sfirst;
  logic slast;

  modport master (
    output sdata, svalid, sfirst, slast,
    input  sready
  );

  modport slave (
    input  sdata, svalid, sfirst, slast,
    output sready
  );
endinterface

// File: rtl/reg_readback_serializer.sv
// Snapshots a register Q bus on start and streams it out one bit per beat.
// Define READBACK_PARITY_EN to append an even-parity beat to every frame.
module reg_readback_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  reg_readback_serializer_if.master s
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef READBACK_PARITY_EN
  localparam int NBEATS = WIDTH + 1;
`else
  localparam int NBEATS = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] sh_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic             first_bit;
  logic             nxt_bit;
  logic             sdata_q;
  logic             svalid_q;
  logic             sfirst_q;
  logic             slast_q;
`ifdef READBACK_PARITY_EN
  logic             par_q;
`endif

  // The outgoing bit always sits at the shadow edge; shifting exposes the next one.
  always_comb begin
    sh_nxt    = MSB_FIRST ? (shadow << 1) : (shadow >> 1);
    cnt_inc   = cnt + CW'(1);
    first_bit = MSB_FIRST ? q_in[WIDTH-1] : q_in[0];
    nxt_bit   = MSB_FIRST ? sh_nxt[WIDTH-1] : sh_nxt[0];
`ifdef READBACK_PARITY_EN
    if (cnt_inc == CW'(WIDTH))
      nxt_bit = par_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sdata_q  <= 1'b0;
      svalid_q <= 1'b0;
      sfirst_q <= 1'b0;
      slast_q  <= 1'b0;
`ifdef READBACK_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= SHIFT;
            shadow   <= q_in;
            cnt      <= '0;
            busy     <= 1'b1;
            svalid_q <= 1'b1;
            sdata_q  <= first_bit;
            sfirst_q <= 1'b1;
            slast_q  <= (LAST == '0);
`ifdef READBACK_PARITY_EN
            par_q    <= ^q_in;
`endif
          end
        end
        SHIFT: begin
          if (s.sready) begin
            sfirst_q <= 1'b0;
            if (cnt == LAST) begin
              state    <= DONE;
              done     <= 1'b1;
              svalid_q <= 1'b0;
              sdata_q  <= 1'b0;
              slast_q  <= 1'b0;
            end else begin
              cnt     <= cnt_inc;
              shadow  <= sh_nxt;
              sdata_q <= nxt_bit;
              slast_q <= (cnt_inc == LAST);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          svalid_q <= 1'b0;
          sdata_q  <= 1'b0;
          sfirst_q <= 1'b0;
          slast_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s.sdata  = sdata_q;
  assign s.svalid = svalid_q;
  assign s.sfirst = sfirst_q;
  assign s.slast  = slast_q;

endmodule

// File: tb/tb_reg_readback_serializer.sv
// Directed bench for reg_readback_serializer: MSB-first and LSB-first instances.
// Frame vectors carry hand-computed bit sequences and parity.
module tb_reg_readback_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        sready;
  logic [15:0] q0, q1;
  logic        busy0, busy1;
  logic        done0, done1;

  always #5 clk = ~clk;

  reg_readback_serializer_if s0 ();
  reg_readback_serializer_if s1 ();

  assign s0.sready = sready;
  assign s1.sready = sready;

  reg_readback_serializer #(
    .WIDTH(16),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start0),
    .q_in(q0),
    .busy(busy0),
    .done(done0),
    .s(s0)
  );

  reg_readback_serializer #(
    .WIDTH(16),
    .MSB_FIRST(1'b0)
  ) dut_lsb (
    .clk(clk),
    .rst(rst),
    .start(start1),
    .q_in(q1),
    .busy(busy1),
    .done(done1),
    .s(s1)
  );

`ifdef READBACK_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  // seq holds the expected data beats in send order, beat 0 at bit 15.
  typedef struct {
    bit          sel;
    logic [15:0] q;
    int          stall_at;
    int          stall_len;
    int          poke_at;
    logic [15:0] seq;
    logic        par;
  } vec_t;

  vec_t vecs[6];
  vec_t vrst;
  int   checks = 0;
  int   errors = 0;
  bit   sel = 1'b0;

  logic o_sdata, o_svalid, o_sfirst, o_slast, o_busy, o_done;

  assign o_sdata  = sel ? s1.sdata  : s0.sdata;
  assign o_svalid = sel ? s1.svalid : s0.svalid;
  assign o_sfirst = sel ? s1.sfirst : s0.sfirst;
  assign o_slast  = sel ? s1.slast  : s0.slast;
  assign o_busy   = sel ? busy1     : busy0;
  assign o_done   = sel ? done1     : done0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_q(input logic [15:0] q);
    if (sel) q1 = q;
    else     q0 = q;
  endtask

  task automatic set_start(input logic b);
    if (sel) start1 = b;
    else     start0 = b;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_svalid"}, o_svalid, 0);
    chk({tag, "_sdata"},  o_sdata,  0);
    chk({tag, "_busy"},   o_busy,   0);
    chk({tag, "_done"},   o_done,   0);
    chk({tag, "_sfirst"}, o_sfirst, 0);
    chk({tag, "_slast"},  o_slast,  0);
  endtask

  task automatic run_frame(input vec_t v);
    int   beat;
    int   stall_left;
    int   cyc;
    bit   poked;
    logic exp_bit;
    sel = v.sel;
    @(negedge clk);
    set_q(v.q);
    set_start(1'b1);
    sready = 1'b1;
    @(negedge clk);
    set_start(1'b0);
    beat = 0;
    stall_left = v.stall_len;
    cyc = 0;
    poked = 1'b0;
    while (beat < NB && cyc < 200) begin
      exp_bit = (beat < 16) ? v.seq[15-beat] : v.par;
      chk("svalid", o_svalid, 1);
      chk("busy",   o_busy,   1);
      chk("sdata",  o_sdata,  exp_bit);
      chk("sfirst", o_sfirst, (beat == 0));
      chk("slast",  o_slast,  (beat == NB - 1));
      chk("done_early", o_done, 0);
      set_start(1'b0);
      if (beat == v.poke_at && !poked) begin
        set_q(16'hFFFF);
        set_start(1'b1);
        poked = 1'b1;
      end
      if (beat == v.stall_at && stall_left > 0) begin
        sready = 1'b0;
        stall_left--;
      end else begin
        sready = 1'b1;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    set_start(1'b0);
    sready = 1'b1;
    chk("frame_len", cyc, NB + v.stall_len);
    chk("done",        o_done,   1);
    chk("done_svalid", o_svalid, 0);
    chk("done_sdata",  o_sdata,  0);
    chk("done_busy",   o_busy,   1);
    chk("done_slast",  o_slast,  0);
    @(negedge clk);
    chk_idle("post1");
    @(negedge clk);
    chk_idle("post2");
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'hA5C3, 99, 0, -1, 16'hA5C3, 1'b0};
    vecs[1] = '{1'b0, 16'hA5C3, 3,  3, -1, 16'hA5C3, 1'b0};
    vecs[2] = '{1'b0, 16'h00FF, 99, 0, 4,  16'h00FF, 1'b0};
    vecs[3] = '{1'b1, 16'h0003, 99, 0, -1, 16'hC000, 1'b0};
    vecs[4] = '{1'b0, 16'h0001, 99, 0, -1, 16'h0001, 1'b1};
    vecs[5] = '{1'b1, 16'h00F1, 2,  1, -1, 16'h8F00, 1'b1};
    vrst    = '{1'b0, 16'h8001, 99, 0, -1, 16'h8001, 1'b0};

    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    q0 = 16'h0;
    q1 = 16'h0;
    sready = 1'b0;
    repeat (2) @(negedge clk);
    sel = 1'b0;
    chk_idle("rst_msb");
    sel = 1'b1;
    chk_idle("rst_lsb");
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i]);

    // Abort a frame at beat 7 with reset, then a clean frame.
    sel = 1'b0;
    @(negedge clk);
    q0 = 16'hA5C3;
    start0 = 1'b1;
    sready = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_sdata", o_sdata, 1);
    chk("pre_rst_busy",  o_busy,  1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("abort1");
    @(negedge clk);
    chk_idle("abort2");
    run_frame(vrst);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
